// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit driving a byte-lane data memory with registered read
// Optional feature macro: LSU_MISALIGN_SPLIT_EN (misaligned accesses split into two word accesses).
module load_store_unit #(
  parameter int MEM_SIZE = 256
) (
  input  logic        Clk_Core,
  input  logic        Rst_Core_N,
  input  logic        Lsu_Req,
  output logic        Lsu_Ready,
  input  logic        Lsu_We,
  input  logic [2:0]  Lsu_Funct3,
  input  logic [31:0] Lsu_Addr,
  input  logic [31:0] Lsu_Wdata,
  output logic [31:0] Lsu_Rdata,
  output logic        Lsu_Done,
  output logic        Lsu_Fault,
  output logic        Read_Ctrl,
  output logic [3:0]  Write_Ctrl,
  output logic [31:0] Mem_Data_Address,
  output logic [31:0] Mem_Data_Write,
  input  logic [31:0] Mem_Data_Read
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ACC0, CAP0, ACC1, CAP1, DONE} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        split_q, split_d;
  logic        fault_q, fault_d;
  logic [31:0] r0_q, r0_d;
  logic [31:0] rdata_q, rdata_d;

  // Request classification, evaluated only while a request can be accepted
  logic        req_legal, req_mis, req_split, req_fault;
  logic [30:0] idx0, idx1;

  always_comb begin
    idx0 = {1'b0, Lsu_Addr[31:2]};
    idx1 = idx0 + 31'd1;
    case (Lsu_Funct3)
      3'b000, 3'b001, 3'b010: req_legal = 1'b1;
      3'b100, 3'b101:         req_legal = !Lsu_We;
      default:                req_legal = 1'b0;
    endcase
    req_mis   = ((Lsu_Funct3[1:0] == 2'b01) && (Lsu_Addr[1:0] == 2'b11)) ||
                ((Lsu_Funct3[1:0] == 2'b10) && (Lsu_Addr[1:0] != 2'b00));
    req_split = req_mis && SplitEn;
    req_fault = !req_legal || (idx0 >= 31'(MEM_SIZE)) ||
                (req_split && (idx1 >= 31'(MEM_SIZE))) || (req_mis && !SplitEn);
  end

  // Byte-lane mask and write data spread over the two-word window
  logic [1:0]  off;
  logic [7:0]  base_mask, mask;
  logic [63:0] wdata_sh;

  always_comb begin
    off = addr_q[1:0];
    case (funct3_q[1:0])
      2'b00:   base_mask = 8'h01;
      2'b01:   base_mask = 8'h03;
      default: base_mask = 8'h0F;
    endcase
    mask     = base_mask << off;
    wdata_sh = {32'b0, wdata_q} << {off, 3'b000};
  end

  // Load alignment; in CAP1 the upper word comes straight off the memory bus
  logic [63:0] rd_pair;
  logic [31:0] rd_sh, load_val;

  always_comb begin
    rd_pair = (state_q == CAP1) ? {Mem_Data_Read, r0_q} : {32'b0, Mem_Data_Read};
    rd_sh   = rd_pair[{off, 3'b000} +: 32];
    case (funct3_q)
      3'b000:  load_val = {{24{rd_sh[7]}}, rd_sh[7:0]};
      3'b001:  load_val = {{16{rd_sh[15]}}, rd_sh[15:0]};
      3'b100:  load_val = {24'b0, rd_sh[7:0]};
      3'b101:  load_val = {16'b0, rd_sh[15:0]};
      default: load_val = rd_sh;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    we_d             = we_q;
    funct3_d         = funct3_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    split_d          = split_q;
    fault_d          = fault_q;
    r0_d             = r0_q;
    rdata_d          = rdata_q;
    Read_Ctrl        = 1'b0;
    Write_Ctrl       = 4'b0;
    Mem_Data_Address = 32'b0;
    Mem_Data_Write   = 32'b0;
    case (state_q)
      IDLE: begin
        if (Lsu_Req) begin
          we_d     = Lsu_We;
          funct3_d = Lsu_Funct3;
          addr_d   = Lsu_Addr;
          wdata_d  = Lsu_Wdata;
          split_d  = req_split;
          fault_d  = req_fault;
          if (req_fault) begin
            rdata_d = 32'b0;
            state_d = DONE;
          end else begin
            state_d = ACC0;
          end
        end
      end
      ACC0: begin
        Mem_Data_Address = {addr_q[31:2], 2'b00};
        if (we_q) begin
          Write_Ctrl     = mask[3:0];
          Mem_Data_Write = wdata_sh[31:0];
          state_d        = split_q ? ACC1 : DONE;
        end else begin
          Read_Ctrl = 1'b1;
          state_d   = CAP0;
        end
      end
      CAP0: begin
        if (split_q) begin
          r0_d    = Mem_Data_Read;
          state_d = ACC1;
        end else begin
          rdata_d = load_val;
          state_d = DONE;
        end
      end
      ACC1: begin
        Mem_Data_Address = {addr_q[31:2] + 30'd1, 2'b00};
        if (we_q) begin
          Write_Ctrl     = mask[7:4];
          Mem_Data_Write = wdata_sh[63:32];
          state_d        = DONE;
        end else begin
          Read_Ctrl = 1'b1;
          state_d   = CAP1;
        end
      end
      CAP1: begin
        rdata_d = load_val;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b0;
      addr_q   <= 32'b0;
      wdata_q  <= 32'b0;
      split_q  <= 1'b0;
      fault_q  <= 1'b0;
      r0_q     <= 32'b0;
      rdata_q  <= 32'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      split_q  <= split_d;
      fault_q  <= fault_d;
      r0_q     <= r0_d;
      rdata_q  <= rdata_d;
    end
  end

  assign Lsu_Ready = (state_q == IDLE);
  assign Lsu_Done  = (state_q == DONE);
  assign Lsu_Fault = (state_q == DONE) && fault_q;
  assign Lsu_Rdata = rdata_q;

endmodule
